image_stream_reader: RTL and testbench

Sequential fetch engine that sits directly downstream of the 300x300 image ROM: on a start pulse it walks ROM addresses 0 to PIXEL_COUNT-1 through one ROM read port, absorbs the ROM's one-cycle registered read latency, and presents the pixels as a valid/ready stream to the processing pipeline. A two-entry output buffer supports full throughput and lossless backpressure.

---
 rtl/image_stream_reader.sv | 139 +++++++++++++
 tb/tb_image_stream_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_reader.sv
// Sequential ROM fetch engine presenting one frame of pixels as a valid/ready stream.
// Optional build macro IMAGE_STREAM_GRAYSCALE_EN converts each captured pixel to {Y,Y,Y}.

// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing ROM reads while the buffer has room
// DRAIN  | all reads issued; emptying buffer and in-flight read
// DONE   | one-cycle done pulse, then back to IDLE
module image_stream_reader #(
  parameter int PIXEL_COUNT = 90000,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 24
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_read_enable,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_read_data,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_last
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  in_flight_q;
  logic                  in_flight_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q, occ_d;

  logic                  issue, push, pop, at_last_addr;
  logic [2:0]            pending;
  logic [DATA_WIDTH-1:0] captured;

`ifdef IMAGE_STREAM_GRAYSCALE_EN
  logic [9:0] luma_sum;
  assign luma_sum = {2'b00, rom_read_data[23:16]} + {1'b0, rom_read_data[15:8], 1'b0}
                  + {2'b00, rom_read_data[7:0]};
  assign captured = {luma_sum[9:2], luma_sum[9:2], luma_sum[9:2]};
`else
  assign captured = rom_read_data;
`endif

  assign push         = in_flight_q;
  assign pixel_valid  = (occ_q != 2'd0);
  assign pop          = pixel_valid & pixel_ready;
  assign at_last_addr = (issue_cnt_q == LAST_ADDR);
  // Buffered pixels plus the read in flight, net of the pixel leaving this cycle.
  assign pending      = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
  assign occ_d        = occ_q + {1'b0, push} - {1'b0, pop};

  assign pixel_data      = buf_data_q[rd_ptr_q];
  assign pixel_last      = buf_last_q[rd_ptr_q] & pixel_valid;
  assign rom_read_enable = issue;
  assign rom_address     = issue ? issue_cnt_q : addr_q;
  assign busy            = (state_q == STREAM) || (state_q == DRAIN);
  assign done            = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          issue_cnt_d = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (pending < 3'd2) begin
          issue = 1'b1;
          if (at_last_addr) begin
            state_d = DRAIN;
          end else begin
            issue_cnt_d = issue_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Look at next-cycle occupancy so done follows the last handshake directly.
        if ((occ_d == 2'd0) && !in_flight_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      issue_cnt_q      <= '0;
      addr_q           <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      buf_data_q[0]    <= '0;
      buf_data_q[1]    <= '0;
      buf_last_q       <= 2'b00;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      occ_q            <= 2'd0;
    end else begin
      state_q          <= state_d;
      issue_cnt_q      <= issue_cnt_d;
      in_flight_q      <= issue;
      in_flight_last_q <= issue & at_last_addr;
      occ_q            <= occ_d;
      if (issue) begin
        addr_q <= issue_cnt_q;
      end
      if (push) begin
        buf_data_q[wr_ptr_q] <= captured;
        buf_last_q[wr_ptr_q] <= in_flight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_image_stream_reader.sv
// Scoreboard bench for image_stream_reader: reset, full-rate, toggling backpressure,
// stall, ignored start, mid-frame reset and restream.
module tb_image_stream_reader;

  localparam int PC = 600;
  localparam int AW = 10;
  localparam int DW = 24;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          rom_read_enable;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_read_data;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [DW-1:0] pixel_data;
  logic          pixel_last;

  image_stream_reader #(.PIXEL_COUNT(PC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .rom_read_enable (rom_read_enable),
    .rom_address     (rom_address),
    .rom_read_data   (rom_read_data),
    .pixel_valid     (pixel_valid),
    .pixel_ready     (pixel_ready),
    .pixel_data      (pixel_data),
    .pixel_last      (pixel_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    case (a)
      10'd0:   return 24'h112233;
      10'd1:   return 24'h445566;
      10'd2:   return 24'h778899;
      10'd3:   return 24'hAABBCC;
      default: return {a[7:0], ~a[7:0], a[9:2]} ^ 24'hA5C3E1;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_pixel(input logic [AW-1:0] a);
    logic [DW-1:0] p;
    logic [9:0]    y;
    p = rom_fn(a);
`ifdef IMAGE_STREAM_GRAYSCALE_EN
    y = {2'b00, p[23:16]} + {1'b0, p[15:8], 1'b0} + {2'b00, p[7:0]};
    return {y[9:2], y[9:2], y[9:2]};
`else
    y = 10'd0;
    return p ^ {14'd0, y};
`endif
  endfunction

  // ROM with one-cycle registered read
  always @(posedge clock) begin
    if (rom_read_enable) rom_read_data <= rom_fn(rom_address);
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int ready_mode = 1;  // 0: low, 1: high, 2: toggle each cycle
  initial begin
    pixel_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       pixel_ready = 1'b0;
        1:       pixel_ready = 1'b1;
        default: pixel_ready = ~pixel_ready;
      endcase
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            reads, pops, done_cnt, done_cyc, first_valid_cyc, c0;
  logic [AW-1:0] exp_addr;
  bit            mon_en = 1'b0;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", pixel_valid, 1);
        check("hold_data", pixel_data, prev_data);
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_data  = pixel_data;
      if (rom_read_enable) begin
        check("rd_addr", rom_address, exp_addr);
        exp_addr++;
        reads++;
      end
      if (pixel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pixel_valid && pixel_ready) begin
        if (sb.size() == 0) begin
          check("sb_extra_pixel", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pix_data", pixel_data, e.data);
          check("pix_last", pixel_last, e.last);
        end
        pops++;
      end
      check("pending_le_2", (reads - pops <= 2) ? 1 : 0, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_frame();
    sb.delete();
    for (int i = 0; i < PC; i++) sb.push_back('{exp_pixel(AW'(i)), (i == PC - 1)});
    reads = 0;
    pops = 0;
    exp_addr = '0;
    done_cnt = 0;
    first_valid_cyc = -1;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b1;
    c0 = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, (done_cnt != 0) ? 1 : 0, 1);
    repeat (3) @(negedge clock);
    check({tag, "_pulses"}, done_cnt, 1);
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_reads"}, reads, PC);
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (pops < target && n < 4 * PC) begin
      @(negedge clock);
      n++;
    end
    check("wait_pops", (pops >= target) ? 1 : 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rom_read_enable, 0);
    check({tag, "_addr"}, rom_address, 0);
    check({tag, "_valid"}, pixel_valid, 0);
    check({tag, "_data"}, pixel_data, 0);
    check({tag, "_last"}, pixel_last, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check_idle_outputs("idle");
    end

    // full throughput
    ready_mode = 1;
    start_frame();
    check("t1_busy", busy, 1);
    wait_done("t1_done", PC + 50);
    check("t1_first_valid", first_valid_cyc - c0, 3);
    check("t1_done_cyc", done_cyc - c0, PC + 3);

    // toggling backpressure
    ready_mode = 2;
    start_frame();
    wait_done("t2_done", 3 * PC + 50);

    // stall from the start
    ready_mode = 0;
    repeat (3) @(posedge clock);
    start_frame();
    repeat (20) @(negedge clock);
    check("t3_reads", reads, 2);
    check("t3_valid", pixel_valid, 1);
    check("t3_pops", pops, 0);
    ready_mode = 1;
    wait_done("t3_done", PC + 50);

    // ignored start, then reset mid-frame
    start_frame();
    wait_pops(100);
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("t4_busy", busy, 1);
    wait_pops(500);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    mon_en  = 1'b0;
    @(posedge clock);
    #1;
    check_idle_outputs("rst");
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check_idle_outputs("post_rst");
    end

    // fresh frame after reset
    start_frame();
    wait_done("t5_done", PC + 50);
    check("t5_first_valid", first_valid_cyc - c0, 3);
    check("t5_done_cyc", done_cyc - c0, PC + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
